// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// HAZARD_STATS_EN enables the stall/flush cycle counters in hazard_unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 32;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running wrap-around stall and flush cycle counters.
// Only built when HAZARD_STATS_EN is defined.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_cycles
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 1'b1;
      if (flush) flush_cycles <= flush_cycles + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / redirect / memory-wait hazard controller for the 5-stage pipe.
// Define HAZARD_STATS_EN to build the stall/flush cycle counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              ID_EX_MemtoReg,
  input  logic              ID_EX_RegWrite,
  input  logic [4:0]        ID_EX_rd,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_write,
  output logic              ID_EX_flush,
  output logic [1:0]        hz_state,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_cycles
);

  localparam bit MULTI = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LOAD_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz_lu, hz_rd;

  assign hz_lu = ID_EX_MemtoReg & ID_EX_RegWrite
               & (ID_EX_rd != REG_ZERO)
               & ((ID_EX_rd == id_rs)
                 | (id_uses_rt & (ID_EX_rd == id_rt)));
  assign hz_rd = ex_branch_taken | ex_jump;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // mem_busy freezes state and cnt so no bubble is lost
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    priority case (1'b1)
      mem_busy: ;
      hz_rd: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      (state_q == LOAD_STALL): begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RUN;
      end
      (hz_lu && MULTI): begin
        state_d = LOAD_STALL;
        cnt_d   = LAT_INIT;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_write = 1'b1;
    ID_EX_flush = 1'b0;
    if (reset) begin
      priority case (1'b1)
        mem_busy: begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_write = 1'b0;
        end
        hz_rd: begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end
        (state_q == LOAD_STALL) || hz_lu: begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_STATS_EN
  hazard_perf_cnt u_perf (
    .clock        (clock),
    .reset        (reset),
    .stall        (~pc_write),
    .flush        (IF_ID_flush),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: LOAD_LAT=1 and LOAD_LAT=3 side by side.
// Expected control vectors are queued per cycle and popped at negedge.
module tb_hazard_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_mtr, ex_rw, br, jp, mem_busy;

  logic        pw1, ifw1, iff1, idw1, idf1;
  logic        pw3, ifw3, iff3, idw3, idf3;
  logic [1:0]  hs1, hs3;
  logic [31:0] sc1, fc1, sc3, fc3;
  logic [6:0]  out1, out3;

  always #5 clock = ~clock;

  hazard_unit #(.LOAD_LAT(1)) u1 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ID_EX_MemtoReg(ex_mtr), .ID_EX_RegWrite(ex_rw),
    .ID_EX_rd(ex_rd), .ex_branch_taken(br), .ex_jump(jp),
    .mem_busy(mem_busy),
    .pc_write(pw1), .IF_ID_write(ifw1), .IF_ID_flush(iff1),
    .ID_EX_write(idw1), .ID_EX_flush(idf1), .hz_state(hs1),
    .stall_cycles(sc1), .flush_cycles(fc1)
  );

  hazard_unit #(.LOAD_LAT(3)) u3 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ID_EX_MemtoReg(ex_mtr), .ID_EX_RegWrite(ex_rw),
    .ID_EX_rd(ex_rd), .ex_branch_taken(br), .ex_jump(jp),
    .mem_busy(mem_busy),
    .pc_write(pw3), .IF_ID_write(ifw3), .IF_ID_flush(iff3),
    .ID_EX_write(idw3), .ID_EX_flush(idf3), .hz_state(hs3),
    .stall_cycles(sc3), .flush_cycles(fc3)
  );

  assign out1 = {pw1, ifw1, iff1, idw1, idf1, hs1};
  assign out3 = {pw3, ifw3, iff3, idw3, idf3, hs3};

  // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, hz_state}
  localparam logic [6:0] NORM    = 7'b11010_00;
  localparam logic [6:0] STALL_R = 7'b00011_00;
  localparam logic [6:0] STALL_L = 7'b00011_01;
  localparam logic [6:0] REDIR_R = 7'b11111_00;
  localparam logic [6:0] REDIR_L = 7'b11111_01;
  localparam logic [6:0] HOLD_R  = 7'b00000_00;
  localparam logic [6:0] HOLD_L  = 7'b00000_01;

  typedef struct {
    logic       mb;
    logic       b;
    logic       j;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic [6:0] e1;
    logic [6:0] e3;
  } step_t;

  logic [6:0]  q1[$], q3[$];
  logic [31:0] st1, fl1, st3, fl3;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic step_t mk(
    input logic mb, input logic b, input logic j, input logic ld,
    input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
    input logic urt, input logic [6:0] e1, input logic [6:0] e3);
    step_t s;
    s.mb = mb; s.b = b; s.j = j; s.ld = ld;
    s.rd = rd; s.rs = rs; s.rt = rt; s.urt = urt;
    s.e1 = e1; s.e3 = e3;
    return s;
  endfunction

  function automatic logic [31:0] cexp(input logic [31:0] m);
`ifdef HAZARD_STATS_EN
    return m;
`else
    return m & 32'h0;
`endif
  endfunction

  task automatic set_in(input step_t s);
    mem_busy = s.mb; br = s.b; jp = s.j;
    ex_mtr = s.ld; ex_rw = s.ld; ex_rd = s.rd;
    id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt;
  endtask

  // drives a step, queues its expectations and advances the counter model
  task automatic apply(input step_t s);
    set_in(s);
    q1.push_back(s.e1);
    q3.push_back(s.e3);
    if (!s.e1[6]) st1++;
    if (s.e1[4]) fl1++;
    if (!s.e3[6]) st3++;
    if (s.e3[4]) fl3++;
  endtask

  task automatic test_reset();
    logic [6:0] x1, x3;
    set_in(mk(1, 0, 0, 1, 5'd8, 5'd8, 5'd8, 1, NORM, NORM));
    q1.push_back(NORM);
    q3.push_back(NORM);
    @(negedge clock);
    x1 = q1.pop_front(); x3 = q3.pop_front();
    n_chk += 4;
    if (out1 !== x1) begin
      n_fail++; $display("FAIL reset lat1 got %b want %b", out1, x1);
    end
    if (out3 !== x3) begin
      n_fail++; $display("FAIL reset lat3 got %b want %b", out3, x3);
    end
    if (sc3 !== 32'd0) begin
      n_fail++; $display("FAIL reset stall_cycles got %0d want 0", sc3);
    end
    if (fc3 !== 32'd0) begin
      n_fail++; $display("FAIL reset flush_cycles got %0d want 0", fc3);
    end
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, NORM, NORM));
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_load_rs();
    step_t s[$];
    logic [6:0] x1, x3;
    s.push_back(mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, STALL_R, STALL_R));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd4, 5'd5, 0, NORM, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd4, 5'd5, 0, NORM, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd4, 5'd5, 0, NORM, NORM));
    foreach (s[i]) begin
      apply(s[i]);
      @(negedge clock);
      x1 = q1.pop_front(); x3 = q3.pop_front();
      n_chk += 2;
      if (out1 !== x1) begin
        n_fail++; $display("FAIL load_rs[%0d] lat1 got %b want %b", i, out1, x1);
      end
      if (out3 !== x3) begin
        n_fail++; $display("FAIL load_rs[%0d] lat3 got %b want %b", i, out3, x3);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_rt();
    step_t s[$];
    logic [6:0] x1, x3;
    s.push_back(mk(0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 1, STALL_R, STALL_R));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd3, 5'd8, 1, NORM, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd3, 5'd8, 1, NORM, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd3, 5'd8, 1, NORM, NORM));
    s.push_back(mk(0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 0, NORM, NORM));
    s.push_back(mk(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, NORM, NORM));
    s.push_back(mk(0, 0, 0, 1, 5'd9, 5'd8, 5'd10, 1, NORM, NORM));
    foreach (s[i]) begin
      apply(s[i]);
      @(negedge clock);
      x1 = q1.pop_front(); x3 = q3.pop_front();
      n_chk += 2;
      if (out1 !== x1) begin
        n_fail++; $display("FAIL load_rt[%0d] lat1 got %b want %b", i, out1, x1);
      end
      if (out3 !== x3) begin
        n_fail++; $display("FAIL load_rt[%0d] lat3 got %b want %b", i, out3, x3);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_redirect();
    step_t s[$];
    logic [6:0] x1, x3;
    s.push_back(mk(0, 1, 0, 1, 5'd8, 5'd8, 5'd8, 1, REDIR_R, REDIR_R));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, NORM, NORM));
    s.push_back(mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 0, STALL_R, STALL_R));
    s.push_back(mk(0, 0, 1, 0, 5'd0, 5'd1, 5'd1, 0, REDIR_R, REDIR_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, NORM, NORM));
    foreach (s[i]) begin
      apply(s[i]);
      @(negedge clock);
      x1 = q1.pop_front(); x3 = q3.pop_front();
      n_chk += 2;
      if (out1 !== x1) begin
        n_fail++; $display("FAIL redirect[%0d] lat1 got %b want %b", i, out1, x1);
      end
      if (out3 !== x3) begin
        n_fail++; $display("FAIL redirect[%0d] lat3 got %b want %b", i, out3, x3);
      end
      @(posedge clock); #1;
    end
    n_chk += 2;
    if (fc1 !== cexp(fl1)) begin
      n_fail++; $display("FAIL redirect flush_cycles lat1 got %0d want %0d", fc1, cexp(fl1));
    end
    if (fc3 !== cexp(fl3)) begin
      n_fail++; $display("FAIL redirect flush_cycles lat3 got %0d want %0d", fc3, cexp(fl3));
    end
  endtask

  task automatic test_mem_busy();
    step_t s[$];
    logic [6:0] x1, x3;
    logic [31:0] base3;
    base3 = st3;
    s.push_back(mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL_R, STALL_R));
    s.push_back(mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, HOLD_R, HOLD_L));
    s.push_back(mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, HOLD_R, HOLD_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, NORM, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, NORM, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, NORM, NORM));
    foreach (s[i]) begin
      apply(s[i]);
      @(negedge clock);
      x1 = q1.pop_front(); x3 = q3.pop_front();
      n_chk += 2;
      if (out1 !== x1) begin
        n_fail++; $display("FAIL mem_busy[%0d] lat1 got %b want %b", i, out1, x1);
      end
      if (out3 !== x3) begin
        n_fail++; $display("FAIL mem_busy[%0d] lat3 got %b want %b", i, out3, x3);
      end
      @(posedge clock); #1;
    end
    n_chk += 2;
    if (sc3 !== cexp(base3 + 32'd5)) begin
      n_fail++; $display("FAIL mem_busy stall_cycles lat3 got %0d want %0d", sc3, cexp(base3 + 32'd5));
    end
    if (sc1 !== cexp(st1)) begin
      n_fail++; $display("FAIL mem_busy stall_cycles lat1 got %0d want %0d", sc1, cexp(st1));
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    logic [6:0] x1, x3;
    s.push_back(mk(1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, HOLD_R, HOLD_R));
    s.push_back(mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL_R, STALL_R));
    s.push_back(mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL_R, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, NORM, STALL_L));
    s.push_back(mk(0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, NORM, NORM));
    foreach (s[i]) begin
      apply(s[i]);
      @(negedge clock);
      x1 = q1.pop_front(); x3 = q3.pop_front();
      n_chk += 2;
      if (out1 !== x1) begin
        n_fail++; $display("FAIL b2b[%0d] lat1 got %b want %b", i, out1, x1);
      end
      if (out3 !== x3) begin
        n_fail++; $display("FAIL b2b[%0d] lat3 got %b want %b", i, out3, x3);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [6:0] x1, x3;
    apply(mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL_R, STALL_R));
    @(negedge clock);
    x1 = q1.pop_front(); x3 = q3.pop_front();
    n_chk += 2;
    if (out1 !== x1) begin
      n_fail++; $display("FAIL rst_mid pre lat1 got %b want %b", out1, x1);
    end
    if (out3 !== x3) begin
      n_fail++; $display("FAIL rst_mid pre lat3 got %b want %b", out3, x3);
    end
    @(posedge clock); #1;
    set_in(mk(1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, NORM, NORM));
    #1 reset = 1'b0;
    #1;
    q3.push_back(NORM);
    x3 = q3.pop_front();
    n_chk += 1;
    if (out3 !== x3) begin
      n_fail++; $display("FAIL rst_mid async lat3 got %b want %b", out3, x3);
    end
    st1 = 0; fl1 = 0; st3 = 0; fl3 = 0;
    @(posedge clock); #1;
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, NORM, NORM));
    @(posedge clock); #1;
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 5'd0, 5'd1, 5'd1, 0, NORM, NORM));
    @(negedge clock);
    x1 = q1.pop_front(); x3 = q3.pop_front();
    n_chk += 4;
    if (out3 !== x3) begin
      n_fail++; $display("FAIL rst_mid post lat3 got %b want %b", out3, x3);
    end
    if (out1 !== x1) begin
      n_fail++; $display("FAIL rst_mid post lat1 got %b want %b", out1, x1);
    end
    if (sc3 !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid stall_cycles got %0d want 0", sc3);
    end
    if (fc1 !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid flush_cycles got %0d want 0", fc1);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    st1 = 0; fl1 = 0; st3 = 0; fl3 = 0;
    test_reset();
    test_load_rs();
    test_load_rt();
    test_redirect();
    test_mem_busy();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS datapath. It drives the ID/EX pipeline register and the upstream PC and IF/ID registers. Each cycle it decides whether the pipeline advances, freezes, or has a bubble inserted, based on load-use dependences, taken branches/jumps resolved in EX, and data-memory wait. It holds a small FSM plus a counter for multi-cycle load-use stalls.

## Interface
- LOAD_LAT, 1: number of bubble cycles inserted on a load-use hazard (1..15)
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ID_EX_MemtoReg  in  1  instruction in EX is a load
- ID_EX_RegWrite  in  1  instruction in EX writes the register file
- ID_EX_rd  in  5  destination register of EX instruction (after RegDst mux)
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_jump  in  1  jump in EX
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID loads a NOP
- ID_EX_write  out  1  ID/EX load enable
- ID_EX_flush  out  1  ID/EX loads all-zero controls (bubble)
- hz_state  out  2  current FSM state, for debug
- stall_cycles  out  32  stall cycle count (macro-gated)
- flush_cycles  out  32  flush cycle count (macro-gated)

## Operation
- States: RUN, LOAD_STALL. 4-bit down-counter `cnt`.
- The load-use condition is `hz_lu`: ID_EX_MemtoReg & ID_EX_RegWrite & ID_EX_rd!=0 & (ID_EX_rd==id_rs | (id_uses_rt & ID_EX_rd==id_rt)).
- `hz_rd` = ex_branch_taken | ex_jump.
- Priority per cycle: mem_busy > hz_rd > hz_lu / LOAD_STALL > normal.
- **mem_busy:**
  - pc_write, IF_ID_write and ID_EX_write = 0; both flushes = 0.
  - FSM and cnt frozen.
- **hz_rd:**
  - pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_write=1, ID_EX_flush=1.
  - Next state RUN; this also aborts any LOAD_STALL.
- **RUN with hz_lu:**
  - pc_write=0, IF_ID_write=0, ID_EX_write=1, ID_EX_flush=1.
  - If LOAD_LAT>1: next state LOAD_STALL, cnt<=LOAD_LAT-1. Otherwise stay in RUN.
- **LOAD_STALL:**
  - Same outputs as RUN with hz_lu.
  - If cnt==1, next state RUN; otherwise cnt<=cnt-1.
  - hz_lu is ignored, because EX holds a bubble.
- **Normal:** all write enables 1, flushes 0.
- Outputs are combinational (Mealy) from state and inputs; only state, cnt and the counters are registered.
- **Reset (reset low):**
  - State RUN, cnt=0, counters 0.
  - Outputs forced to pc_write=1, IF_ID_write=1, ID_EX_write=1, flushes 0, hz_state=RUN.
  - Reset mid-stall abandons the stall immediately.

## Timing
- Stall and flush take effect in the detection cycle; there is no added latency.
- A load-use hazard costs exactly LOAD_LAT cycles.
- A redirect costs 2 cycles (the IF/ID and ID/EX contents are discarded).
- A mem_busy cycle inside LOAD_STALL does not consume cnt, so the total bubble count is preserved.
- State and cnt update only on the rising clock edge when mem_busy=0.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cycles increments on every cycle with pc_write=0 (load-use or mem_busy).
  - flush_cycles increments on every hz_rd cycle.
  - Both are 32-bit, wrap at 2^32-1 → 0, and are reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are built.

## Structure
- hazard_pkg holds:
  - the state encoding (RUN=2'd0, LOAD_STALL=2'd1);
  - REG_ZERO=5'd0;
  - the counter width constant.
- Sub-module hazard_perf_cnt holds the two wrap-around counters and is instantiated only under HAZARD_STATS_EN.

## Test plan
- **Load-use, LOAD_LAT=1:** load to $8 in EX, ID reads rs=$8 → one cycle with pc_write=0, IF_ID_write=0, ID_EX_flush=1. Next cycle all enables 1.
- **Load-use, LOAD_LAT=3:** load to $8 in EX, ID reads rt=$8 with id_uses_rt=1 → 3 consecutive bubble cycles with hz_state=1 for cycles 2–3, then RUN. With id_uses_rt=0 → no stall.
- **Zero register:** ID_EX_rd=0 with a matching rs → no stall.
- **Redirect vs load-use:** ex_branch_taken=1 while hz_lu=1 → IF_ID_flush=1, ID_EX_flush=1, pc_write=1, no stall. flush_cycles increments by 1.
- **mem_busy inside a stall:** LOAD_LAT=3, mem_busy=1 for 2 cycles during LOAD_STALL → all enables 0 and cnt held. Total bubbles still 3; stall_cycles increases by 5.
- **Reset mid-stall:** reset low during LOAD_STALL → hz_state=0 and enables 1 asynchronously; counters read 0 after release.
